// File: rtl/reg_bank_hs.sv
// Register bank with req/ack handshake: config registers (R/W), status registers (RO or sticky W1C).
// Optional compile-time config write lock enabled by defining CFG_LOCK_EN.
module reg_bank_hs #(
    parameter int REG_W      = 8,
    parameter int ADDR_W     = 8,
    parameter int NUM_CFG    = 8,
    parameter int NUM_STATUS = 8,
    parameter logic [NUM_STATUS-1:0] STICKY_MASK = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          req,
    input  logic                          wr_rdn,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [REG_W-1:0]              wdata,
    output logic [REG_W-1:0]              rdata,
    output logic                          ack,
    output logic                          err,
    output logic [NUM_CFG-1:0]            cfg_wr_stb,
    input  logic                          lock,
    output logic [NUM_CFG*REG_W-1:0]      rw_regs,
    input  logic [NUM_STATUS*REG_W-1:0]   ro_regs
);

    // Handshake: a request is taken on every clock edge with ena & req (no backpressure);
    // ack/err/rdata/cfg_wr_stb for it are valid for exactly the following cycle.
    logic [NUM_CFG-1:0][REG_W-1:0]    r_cfg;
    logic [NUM_STATUS-1:0][REG_W-1:0] r_sticky;
    logic [REG_W-1:0]                 r_rdata;
    logic                             r_ack;
    logic                             r_err;
    logic [NUM_CFG-1:0]               r_stb;

    logic [NUM_STATUS-1:0][REG_W-1:0] w_ro;
    logic                             w_accept;
    logic                             w_is_status;
    logic [31:0]                      w_idx_ext;
    logic                             w_cfg_hit;
    logic                             w_st_hit;
    logic                             w_st_sticky;
    logic [REG_W-1:0]                 w_cfg_rd;
    logic [REG_W-1:0]                 w_st_rd;
    logic [NUM_CFG-1:0]               w_cfg_sel;
    logic [NUM_STATUS-1:0]            w_st_sel;
    logic                             w_locked;
    logic                             w_legal;
    logic [REG_W-1:0]                 w_rd_val;
    logic [NUM_CFG-1:0]               w_cfg_we;
    logic [NUM_STATUS-1:0]            w_st_clr_en;

`ifdef CFG_LOCK_EN
    assign w_locked = lock;
`else
    logic w_unused_lock;
    assign w_unused_lock = lock;
    assign w_locked      = 1'b0;
`endif

    assign w_ro        = ro_regs;
    assign rw_regs     = r_cfg;
    assign w_accept    = ena & req;
    assign w_is_status = addr[ADDR_W-1];

    always_comb begin
        w_idx_ext                = '0;
        w_idx_ext[ADDR_W-2:0]    = addr[ADDR_W-2:0];
        w_cfg_hit   = 1'b0;
        w_st_hit    = 1'b0;
        w_st_sticky = 1'b0;
        w_cfg_rd    = '0;
        w_st_rd     = '0;
        w_cfg_sel   = '0;
        w_st_sel    = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (!w_is_status && w_idx_ext == 32'(i)) begin
                w_cfg_hit    = 1'b1;
                w_cfg_sel[i] = 1'b1;
                w_cfg_rd     = r_cfg[i];
            end
        end
        for (int i = 0; i < NUM_STATUS; i++) begin
            if (w_is_status && w_idx_ext == 32'(i)) begin
                w_st_hit    = 1'b1;
                w_st_sel[i] = 1'b1;
                w_st_sticky = STICKY_MASK[i];
                // Sticky reads return the captured value from before this edge.
                w_st_rd     = STICKY_MASK[i] ? r_sticky[i] : w_ro[i];
            end
        end
    end

    assign w_legal     = w_cfg_hit ? !(wr_rdn && w_locked)
                       : w_st_hit  ? (!wr_rdn || w_st_sticky)
                       : 1'b0;
    assign w_rd_val    = (!w_legal || wr_rdn) ? '0 : (w_cfg_hit ? w_cfg_rd : w_st_rd);
    assign w_cfg_we    = (w_accept && wr_rdn && w_legal && w_cfg_hit) ? w_cfg_sel : '0;
    assign w_st_clr_en = (w_accept && wr_rdn && w_legal && w_st_hit) ? w_st_sel : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg    <= '0;
            r_sticky <= '0;
            r_rdata  <= '0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_stb    <= '0;
        end else begin
            r_ack <= w_accept;
            r_err <= w_accept && !w_legal;
            r_stb <= w_cfg_we;
            if (w_accept) begin
                r_rdata <= w_rd_val;
            end
            for (int i = 0; i < NUM_CFG; i++) begin
                if (w_cfg_we[i]) begin
                    r_cfg[i] <= wdata;
                end
            end
            // Set dominates clear: the live status bits are ORed in after the W1C mask.
            if (ena) begin
                for (int i = 0; i < NUM_STATUS; i++) begin
                    if (STICKY_MASK[i]) begin
                        r_sticky[i] <= (r_sticky[i] & ~(w_st_clr_en[i] ? wdata : '0)) | w_ro[i];
                    end else begin
                        r_sticky[i] <= '0;
                    end
                end
            end
        end
    end

    assign rdata      = r_rdata;
    assign ack        = r_ack;
    assign err        = r_err;
    assign cfg_wr_stb = r_stb;

endmodule
